// File: rtl/acc_cpu_core.sv
// rtl/acc_cpu_core.sv - parametrised accumulator CPU core with fetch/decode/execute FSM
module acc_cpu_core #(
    parameter  int DATA_W  = 8,
    parameter  int ADDR_W  = 5,
    localparam int INSTR_W = 3 + ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]  dmem_addr,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic               dmem_we,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr,
    output logic [DATA_W-1:0]  acc,
    output logic               zero,
    output logic               carry,
    output logic               retire,
    output logic               halted
);

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STA = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] instr_q;
    logic [DATA_W-1:0]  acc_q;
    logic               zero_q;
    logic               carry_q;
    logic               we_q;
    logic               retire_q;
    logic               halted_q;

    logic [ADDR_W-1:0]  pc_d;
    logic [DATA_W-1:0]  acc_d;
    logic               zero_d;
    logic               carry_d;

    logic [2:0]         op;
    logic [ADDR_W-1:0]  operand;
    logic [DATA_W-1:0]  imm;
    logic [DATA_W:0]    sum;
    logic [DATA_W:0]    diff;

    assign op      = instr_q[INSTR_W-1:ADDR_W];
    assign operand = instr_q[ADDR_W-1:0];
    assign imm     = DATA_W'(operand);
    assign sum     = {1'b0, acc_q} + {1'b0, dmem_rdata};
    // The extra top bit of the widened difference is the borrow.
    assign diff    = {1'b0, acc_q} - {1'b0, dmem_rdata};

    always_comb begin
        pc_d    = pc_q + ADDR_W'(1);
        acc_d   = acc_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        case (op)
            OP_HLT: pc_d = pc_q;
            OP_LDI: begin
                acc_d   = imm;
                zero_d  = (imm == '0);
                carry_d = 1'b0;
            end
            OP_LDA: begin
                acc_d   = dmem_rdata;
                zero_d  = (dmem_rdata == '0);
                carry_d = 1'b0;
            end
            OP_ADD: begin
                acc_d   = sum[DATA_W-1:0];
                zero_d  = (sum[DATA_W-1:0] == '0);
                carry_d = sum[DATA_W];
            end
            OP_SUB: begin
                acc_d   = diff[DATA_W-1:0];
                zero_d  = (diff[DATA_W-1:0] == '0);
                carry_d = diff[DATA_W];
            end
            OP_JZ: begin
                if (zero_q) begin
                    pc_d = operand;
                end
            end
            OP_JMP: pc_d = operand;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            instr_q  <= '0;
            acc_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            we_q     <= 1'b0;
            retire_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            we_q     <= 1'b0;
            retire_q <= 1'b0;
            case (state_q)
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    instr_q  <= imem_data;
                    retire_q <= 1'b1;
                    we_q     <= (imem_data[INSTR_W-1:ADDR_W] == OP_STA);
                    state_q  <= S_EXEC;
                end
                S_EXEC: begin
                    pc_q    <= pc_d;
                    acc_q   <= acc_d;
                    zero_q  <= zero_d;
                    carry_q <= carry_d;
                    if (op == OP_HLT) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        state_q  <= S_FETCH;
                    end
                end
                S_HALT: state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // In DECODE the instruction is not latched yet, so the operand comes straight from the ROM.
    assign dmem_addr  = (state_q == S_DECODE) ? imem_data[ADDR_W-1:0] : operand;
    assign imem_addr  = pc_q;
    assign dmem_wdata = acc_q;
    assign dmem_we    = we_q;
    assign pc         = pc_q;
    assign instr      = instr_q;
    assign acc        = acc_q;
    assign zero       = zero_q;
    assign carry      = carry_q;
    assign retire     = retire_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// tb/tb_acc_cpu_core.sv - self-checking bench for acc_cpu_core against an ISA-level model
module tb_acc_cpu_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset  = 1'b1;
    logic       reset1 = 1'b1;

    logic [4:0] imem_addr, dmem_addr, pc;
    logic [7:0] imem_data, dmem_rdata, dmem_wdata, instr, acc;
    logic       dmem_we, zero, carry, retire, halted;

    logic [7:0] imem_addr1, dmem_addr1, pc1;
    logic [10:0] imem_data1, instr1;
    logic [15:0] dmem_rdata1, dmem_wdata1, acc1;
    logic       dmem_we1, zero1, carry1, retire1, halted1;

    logic [7:0]  rom      [32];
    logic [7:0]  ram      [32];
    logic [7:0]  ram_init [32];
    logic [10:0] rom1      [256];
    logic [15:0] ram1      [256];
    logic [15:0] ram1_init [256];

    acc_cpu_core #(.DATA_W(8), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata), .dmem_wdata(dmem_wdata),
        .dmem_we(dmem_we), .pc(pc), .instr(instr), .acc(acc), .zero(zero),
        .carry(carry), .retire(retire), .halted(halted)
    );

    acc_cpu_core #(.DATA_W(16), .ADDR_W(8)) dut1 (
        .clk(clk), .reset(reset1), .imem_addr(imem_addr1), .imem_data(imem_data1),
        .dmem_addr(dmem_addr1), .dmem_rdata(dmem_rdata1), .dmem_wdata(dmem_wdata1),
        .dmem_we(dmem_we1), .pc(pc1), .instr(instr1), .acc(acc1), .zero(zero1),
        .carry(carry1), .retire(retire1), .halted(halted1)
    );

    always @(posedge clk) begin
        imem_data  <= rom[imem_addr];
        dmem_rdata <= ram[dmem_addr];
        if (reset) begin
            for (int i = 0; i < 32; i++) ram[i] <= ram_init[i];
        end else if (dmem_we) begin
            ram[dmem_addr] <= dmem_wdata;
        end
    end

    always @(posedge clk) begin
        imem_data1  <= rom1[imem_addr1];
        dmem_rdata1 <= ram1[dmem_addr1];
        if (reset1) begin
            for (int i = 0; i < 256; i++) ram1[i] <= ram1_init[i];
        end else if (dmem_we1) begin
            ram1[dmem_addr1] <= dmem_wdata1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // ISA-level reference: one call executes one whole instruction.
    int m_pc, m_acc, m_z, m_c;
    int m_mem [32];
    bit m_halt;

    task automatic model_step();
        int op, k, s;
        op = int'(rom[m_pc][7:5]);
        k  = int'(rom[m_pc][4:0]);
        case (op)
            0: m_halt = 1'b1;
            1: begin m_acc = k; m_c = 0; m_z = (m_acc == 0); end
            2: begin m_acc = m_mem[k]; m_c = 0; m_z = (m_acc == 0); end
            3: m_mem[k] = m_acc;
            4: begin s = m_acc + m_mem[k]; m_c = (s > 255); m_acc = s % 256; m_z = (m_acc == 0); end
            5: begin m_c = (m_acc < m_mem[k]); m_acc = (m_acc - m_mem[k] + 256) % 256; m_z = (m_acc == 0); end
            default: ;
        endcase
        if (op == 7) m_pc = k;
        else if (op == 6 && m_z != 0) m_pc = k;
        else if (op != 0) m_pc = (m_pc + 1) % 32;
    endtask

    task automatic run0(input int budget, output int nret, output int halt_cyc);
        int cyc, last, mism;
        reset = 1'b1;
        m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; m_halt = 1'b0;
        for (int i = 0; i < 32; i++) m_mem[i] = int'(ram_init[i]);
        repeat (2) @(negedge clk);
        chk("reset_pc", pc, 0);
        chk("reset_acc", acc, 0);
        chk("reset_halted", halted, 0);
        reset = 1'b0;
        chk("first_imem_addr", imem_addr, 0);
        cyc = 0; last = -1; nret = 0; halt_cyc = -1;
        while (cyc < budget && halt_cyc < 0) begin
            @(negedge clk);
            cyc++;
            if (retire) begin
                chk("pc", pc, m_pc);
                chk("instr", instr, rom[m_pc]);
                chk("acc", acc, m_acc);
                chk("zero", zero, m_z);
                chk("carry", carry, m_c);
                chk("dmem_we", dmem_we, rom[m_pc][7:5] == 3'd3);
                if (rom[m_pc][7:5] == 3'd3) begin
                    chk("sta_addr", dmem_addr, rom[m_pc][4:0]);
                    chk("sta_wdata", dmem_wdata, m_acc);
                end
                if (last >= 0) chk("retire_gap", cyc - last, 3);
                else chk("first_retire_cycle", cyc, 2);
                last = cyc;
                nret++;
                model_step();
            end else begin
                chk("dmem_we_idle", dmem_we, 0);
            end
            if (halted) begin
                halt_cyc = cyc;
                chk("halt_matches_model", m_halt, 1);
            end
        end
        if (m_halt) chk("halt_seen", halt_cyc >= 0, 1);
        if (halt_cyc >= 0) begin
            chk("final_pc", pc, m_pc);
            chk("final_acc", acc, m_acc);
            chk("final_zero", zero, m_z);
            chk("final_carry", carry, m_c);
            mism = 0;
            for (int i = 0; i < 32; i++) if (ram[i] !== m_mem[i][7:0]) mism++;
            chk("dmem_contents", mism, 0);
        end
    endtask

    typedef struct {
        logic [63:0] prog;
        logic [7:0]  rom31;
        logic [7:0]  m1;
        int          budget;
        int          e_acc, e_z, e_c, e_pc, e_nret, e_halt;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int nret, hc, cyc;
        vecs[0] = '{64'h2563_8300_0000_0000, 8'h00, 8'h00, 60, 'h0A, 0, 0, 3, 4, 12};
        vecs[1] = '{64'h3F81_A100_0000_0000, 8'h00, 8'hF0, 60, 'h1F, 0, 1, 3, 4, 12};
        vecs[2] = '{64'h20C7_3F3F_3F3F_3F00, 8'h00, 8'h00, 60, 'h00, 1, 0, 7, 3, 9};
        vecs[3] = '{64'h21C7_0000_0000_0000, 8'h00, 8'h00, 60, 'h01, 0, 0, 2, 3, 9};
        vecs[4] = '{64'hC2FF_0000_0000_0000, 8'h20, 8'h00, 60, 'h00, 1, 0, 2, 5, 15};
        vecs[5] = '{64'hE000_0000_0000_0000, 8'h00, 8'h00, 30, 'h00, 0, 0, 0, 10, -1};
        vecs[6] = '{64'h2964_2044_A400_0000, 8'h00, 8'h00, 60, 'h00, 1, 0, 5, 6, 18};

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 32; i++) begin
                rom[i] = (i < 8) ? vecs[v].prog[63 - 8*i -: 8] : 8'h00;
                ram_init[i] = 8'h00;
            end
            rom[31] = vecs[v].rom31;
            ram_init[1] = vecs[v].m1;
            run0(vecs[v].budget, nret, hc);
            chk($sformatf("v%0d_nret", v), nret, vecs[v].e_nret);
            chk($sformatf("v%0d_halt_cycle", v), hc, vecs[v].e_halt);
            chk($sformatf("v%0d_acc", v), acc, vecs[v].e_acc);
            chk($sformatf("v%0d_zero", v), zero, vecs[v].e_z);
            chk($sformatf("v%0d_carry", v), carry, vecs[v].e_c);
            chk($sformatf("v%0d_pc", v), pc, vecs[v].e_pc);
        end

        // Asynchronous reset landing in the EXEC cycle of an ADD.
        for (int i = 0; i < 32; i++) begin rom[i] = 8'h00; ram_init[i] = 8'h00; end
        rom[0] = 8'h25; rom[1] = 8'h83; ram_init[3] = 8'h07;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        while (cyc < 20 && !(retire && instr == 8'h83)) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_add_exec", cyc, 5);
        chk("acc_before_reset", acc, 5);
        reset = 1'b1;
        #1;
        chk("midrst_pc", pc, 0);
        chk("midrst_acc", acc, 0);
        chk("midrst_instr", instr, 0);
        chk("midrst_flags", {zero, carry}, 0);
        chk("midrst_retire", retire, 0);
        chk("midrst_we", dmem_we, 0);
        chk("midrst_halted", halted, 0);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_imem_addr", imem_addr, 0);
        @(negedge clk);
        chk("midrst_no_retire_c1", retire, 0);
        @(negedge clk);
        chk("midrst_retire_c2", retire, 1);
        chk("midrst_first_instr", instr, 8'h25);

        // Randomised programs checked retire-by-retire against the model.
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 32; i++) begin
                rom[i] = 8'($urandom);
                ram_init[i] = 8'($urandom);
            end
            run0(120, nret, hc);
        end

        // Wider configuration: 16-bit data, 8-bit address.
        for (int i = 0; i < 256; i++) begin rom1[i] = 11'h000; ram1_init[i] = 16'h0000; end
        rom1[0] = 11'h1FF; rom1[1] = 11'h402; rom1[2] = 11'h000;
        ram1_init[2] = 16'hFF01;
        reset1 = 1'b1;
        repeat (2) @(negedge clk);
        reset1 = 1'b0;
        cyc = 0;
        while (cyc < 40 && !halted1) begin
            @(negedge clk);
            cyc++;
        end
        chk("w16_halt_cycle", cyc, 9);
        chk("w16_acc", acc1, 16'h0000);
        chk("w16_zero", zero1, 1);
        chk("w16_carry", carry1, 1);
        chk("w16_pc", pc1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
